// File: rtl/apb_slave_if.sv
// APB bus bundle for the apb_slave register block.
// The master drives select/strobe/address/data; the slave returns
// registered read data, ready and error.
interface apb_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave.sv
// APB register slave: 15 read/write byte registers at 0x00-0x0E and a
// read-only ID byte at 0x0F. WAIT_CYCLES wait states are inserted before
// the single-cycle pready pulse. Every bus output is driven from a flop.
module apb_slave #(
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input logic        pclk,
  input logic        prst,
  apb_slave_if.slave bus
);

  localparam int         NREGS   = 15;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [7:0]             r_prdata;
  logic                   r_pready;
  logic                   r_pslverr;
  logic [NREGS-1:0][7:0]  r_regs;

  logic       w_setup;
  logic       w_access;
  logic       w_in_range;
  logic       w_err;
  logic       w_enter_ready;
  logic       w_commit;
  logic [7:0] w_rdata;

  assign w_setup    = bus.psel && !bus.penable;
  assign w_access   = bus.psel &&  bus.penable;
  assign w_in_range = (bus.paddr[7:4] == 4'h0);
  // Out-of-map accesses and writes to the ID byte are rejected.
  assign w_err      = !w_in_range || (bus.pwrite && (bus.paddr[3:0] == 4'hF));

  // The edge that moves the FSM into READY is the one that samples the
  // response; with no wait states that is the setup edge itself.
  assign w_enter_ready =
      ((r_state == S_IDLE) && w_setup && (WAIT_CYCLES == 0)) ||
      ((r_state == S_WAIT) && w_access && (r_cnt == 4'd1));

  // A write lands on the edge leaving READY, only if the master is still
  // in the access phase and the transfer was not flagged as an error.
  assign w_commit = (r_state == S_READY) && w_access && bus.pwrite && !r_pslverr;

  // Read mux: register file, ID byte, or zero outside the map.
  always_comb begin
    w_rdata = 8'h00;
    if (w_in_range) begin
      if (bus.paddr[3:0] == 4'hF) begin
        w_rdata = ID_VALUE;
      end else begin
        for (int i = 0; i < NREGS; i++) begin
          if (bus.paddr[3:0] == 4'(i)) w_rdata = r_regs[i];
        end
      end
    end
  end

  // Transfer sequencing plus the registered pready/pslverr/prdata.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          // An access phase without a preceding setup is ignored here.
          if (w_setup) begin
            if (WAIT_CYCLES == 0) begin
              r_state <= S_READY;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LD;
            end
          end
        end
        S_WAIT: begin
          if (!bus.psel) begin
            // Master abandoned the transfer.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (bus.penable) begin
            if (r_cnt == 4'd1) begin
              r_state <= S_READY;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        S_READY: begin
          // Always one cycle; a new setup may follow immediately.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase

      // pready/pslverr are pulses tied to the READY cycle; prdata only
      // moves on a read completion and holds otherwise.
      if (w_enter_ready) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_err;
        if (!bus.pwrite) r_prdata <= w_rdata;
      end else begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
      end
    end
  end

  // Register file: cleared on reset, written only on a committed transfer.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_regs <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.paddr[3:0] == 4'(i)) r_regs[i] <= bus.pwdata;
      end
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

endmodule
